// File: rtl/operand_issuer_pkg.sv
// Shared types and constants for the operand issuer and its FIFO.
//   state_t : issue FSM encoding (IDLE=0, LOAD=1, START=2, RUN=3)
//   pair_t  : one {x, y} operand pair as stored in the FIFO
package operand_issuer_pkg;

  localparam int unsigned DEPTH    = 4;  // FIFO depth in operand pairs
  localparam int unsigned WDOG     = 8;  // max RUN cycles before timeout
  localparam int unsigned OP_W     = 4;  // operand width
  localparam int unsigned ISSUED_W = 8;  // completed-issue counter width
  localparam int unsigned PTR_W    = 2;  // FIFO pointer width
  localparam int unsigned LEVEL_W  = 3;  // FIFO occupancy width (0..4)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] x;
    logic [OP_W-1:0] y;
  } pair_t;

endpackage

// File: rtl/operand_issuer_fifo.sv
// op_fifo: 4-entry operand-pair FIFO without full bypass.
//   clk, rst     : clock, async active-high reset
//   push, pop    : requests; push is ignored when full, pop when empty
//   din, dout    : write data / head of queue (dout valid when !empty)
//   full, empty  : occupancy flags decoded from level
//   level        : occupancy 0..DEPTH, kept as its own counter
module op_fifo
  import operand_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = operand_issuer_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  pair_t              din,
  output pair_t              dout,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  pair_t            mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even while it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (level == LEVEL_W'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rptr];

  // Pointers wrap naturally at 2 bits; level tracks occupancy separately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; the pointers and level make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/operand_issuer.sv
// operand_issuer: buffers operand pairs and issues them one at a time to a
// compute core, holding the operands stable while the core runs.
//   clk, rst            : clock, async active-high reset (shared with core)
//   in_valid/in_ready   : upstream pair handshake; in_x, in_y operands
//   core_start          : one-cycle start pulse to the core
//   core_xin, core_yin  : operands from the hold registers
//   core_done           : core completion flag
//   busy                : FSM not in IDLE
//   level               : FIFO occupancy
//   issued              : completed issues, wraps at 256
//   err                 : sticky watchdog timeout
module operand_issuer
  import operand_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = operand_issuer_pkg::DEPTH,
  parameter int unsigned WDOG  = operand_issuer_pkg::WDOG
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_x,
  input  logic [OP_W-1:0]     in_y,
  output logic                core_start,
  output logic [OP_W-1:0]     core_xin,
  output logic [OP_W-1:0]     core_yin,
  input  logic                core_done,
  output logic                busy,
  output logic [LEVEL_W-1:0]  level,
  output logic [ISSUED_W-1:0] issued,
  output logic                err
);

  localparam int unsigned CNT_W = $clog2(WDOG + 1);

  state_t           state;
  state_t           state_nxt;
  pair_t            fifo_din;
  pair_t            fifo_dout;
  pair_t            hold;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [CNT_W-1:0] wdog_cnt;
  logic             wdog_hit;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_din  = pair_t'{x: in_x, y: in_y};

  op_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Timeout on the WDOG-th RUN cycle; a done in that same cycle still wins.
  assign wdog_hit = (state == RUN) && !core_done &&
                    (wdog_cnt == CNT_W'(WDOG - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; core_done outside RUN is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (level != '0) state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (core_done || wdog_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from state only, so core_start never depends on the core.
  always_comb begin
    core_start = 1'b0;
    busy       = 1'b1;
    fifo_pop   = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      LOAD:    fifo_pop = !fifo_empty;
      START:   core_start = 1'b1;
      default: ;
    endcase
  end

  // Hold registers, watchdog, issue counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= '0;
      wdog_cnt <= '0;
      issued   <= '0;
      err      <= 1'b0;
    end else begin
      if (fifo_pop) hold <= fifo_dout;

      if (state == RUN && state_nxt == RUN) wdog_cnt <= wdog_cnt + CNT_W'(1);
      else                                  wdog_cnt <= '0;

      if (state == RUN && core_done) issued <= issued + ISSUED_W'(1);
      if (wdog_hit)                  err    <= 1'b1;
    end
  end

  assign core_xin = hold.x;
  assign core_yin = hold.y;

endmodule

// File: tb/tb_operand_issuer.sv
// Testbench for operand_issuer: behavioural core model, scoreboard of issued
// pairs, and one task per scenario.
module tb_operand_issuer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x;
  logic [3:0] in_y;
  logic       core_start;
  logic [3:0] core_xin;
  logic [3:0] core_yin;
  logic       core_done;
  logic       busy;
  logic [2:0] level;
  logic [7:0] issued;
  logic       err;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];

  // Core model: done on RUN cycle number core_lat after the start pulse.
  int   core_lat   = 3;
  bit   core_never = 1'b0;
  bit   spur       = 1'b0;
  bit   core_act;
  int   core_cnt;
  logic core_done_m;

  always #5 clk = ~clk;

  operand_issuer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .core_start (core_start),
    .core_xin   (core_xin),
    .core_yin   (core_yin),
    .core_done  (core_done),
    .busy       (busy),
    .level      (level),
    .issued     (issued),
    .err        (err)
  );

  assign core_done_m = core_act && !core_never && (core_cnt == core_lat);
  assign core_done   = core_done_m || spur;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_act <= 1'b0;
      core_cnt <= 0;
    end else if (core_start) begin
      core_act <= 1'b1;
      core_cnt <= 1;
    end else if (core_act) begin
      if (core_done_m) core_act <= 1'b0;
      else             core_cnt <= core_cnt + 1;
    end
  end

  // Scoreboard monitor: pops the expected pair on each start pulse and checks
  // that the core operands stay put until the FSM leaves RUN.
  task automatic monitor();
    bit         act = 1'b0;
    bit         prev_start = 1'b0;
    logic [7:0] hold_exp = '0;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (prev_start) begin
          n_cmp++;
          if (core_start !== 1'b0) begin
            n_bad++;
            $display("FAIL start_width: core_start=%b, required 0 on cycle after start", core_start);
          end
        end
        if (core_start) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_issue: issued x=%0d y=%0d, required no issue", core_xin, core_yin);
            act = 1'b0;
          end else begin
            exp = exp_q.pop_front();
            if ({core_xin, core_yin} !== exp) begin
              n_bad++;
              $display("FAIL issue_data: x=%0d y=%0d, required x=%0d y=%0d",
                       core_xin, core_yin, exp[7:4], exp[3:0]);
            end
            hold_exp = exp;
            act = 1'b1;
          end
        end else if (act) begin
          if (busy) begin
            n_cmp++;
            if ({core_xin, core_yin} !== hold_exp) begin
              n_bad++;
              $display("FAIL hold_stable: x=%0d y=%0d, required x=%0d y=%0d",
                       core_xin, core_yin, hold_exp[7:4], hold_exp[3:0]);
            end
          end else begin
            act = 1'b0;
          end
        end
        prev_start = core_start;
      end
    end
  endtask

  // Present a pair and wait (bounded) for the handshake edge.
  task automatic push(input logic [3:0] x, input logic [3:0] y);
    int t = 0;
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    while (!in_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_bad++;
      $display("FAIL push_timeout: in_ready=%b, required 1 within 64 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({x, y});
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((busy || level != 3'd0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (busy || level != 3'd0) begin
      n_bad++;
      $display("FAIL drain_timeout: busy=%b level=%0d, required 0/0", busy, level);
    end
  endtask

  // Returns negedges until core_start is seen (or budget+1 on timeout).
  task automatic wait_start(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!core_start && cycles <= budget);
    if (!core_start) begin
      n_cmp++;
      n_bad++;
      $display("FAIL start_timeout: core_start=%b, required 1 within %0d cycles", core_start, budget);
    end
  endtask

  // Called at the start-pulse negedge; counts RUN cycles until busy drops.
  task automatic count_run(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, level, busy, core_start, issued, err, core_xin, core_yin} !==
        {1'b1, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 4'd0}) begin
      n_bad++;
      $display("FAIL reset_state: rdy=%b lvl=%0d busy=%b start=%b issued=%0d err=%b x=%0d y=%0d, required 1 0 0 0 0 0 0 0",
               in_ready, level, busy, core_start, issued, err, core_xin, core_yin);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int t;
    int n;
    core_lat = 3;
    push(4'd6, 4'd9);
    n_cmp++;
    if (level !== 3'd1) begin
      n_bad++;
      $display("FAIL first_push: level=%0d, required 1", level);
    end
    wait_start(10, t);
    n_cmp++;
    if (t !== 3) begin
      n_bad++;
      $display("FAIL start_latency: %0d cycles, required 3", t);
    end
    count_run(n);
    n_cmp++;
    if (n !== 3) begin
      n_bad++;
      $display("FAIL run_cycles: %0d, required 3", n);
    end
    n_cmp++;
    if ({issued, busy, err, core_xin, core_yin} !== {8'd1, 1'b0, 1'b0, 4'd6, 4'd9}) begin
      n_bad++;
      $display("FAIL single_after: issued=%0d busy=%b err=%b x=%0d y=%0d, required 1 0 0 6 9",
               issued, busy, err, core_xin, core_yin);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] base;
    int         t;
    core_lat = 8;
    base = issued;
    push(4'd1, 4'd1);
    wait_start(10, t);
    for (int i = 0; i < 4; i++) push(4'(i + 2), 4'(15 - i));
    n_cmp++;
    if ({level, in_ready} !== {3'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL fifo_full: level=%0d in_ready=%b, required 4 0", level, in_ready);
    end
    // Fifth pair stays valid through the LOAD pop; it must land one cycle later.
    in_x = 4'd10;
    in_y = 4'd11;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (level == 3'd4 && t < 40);
    n_cmp++;
    if ({level, in_ready} !== {3'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL pop_no_push: level=%0d in_ready=%b, required 3 1", level, in_ready);
    end
    @(posedge clk);
    exp_q.push_back({4'd10, 4'd11});
    #1;
    in_valid = 1'b0;
    n_cmp++;
    if (level !== 3'd4) begin
      n_bad++;
      $display("FAIL refill: level=%0d, required 4", level);
    end
    wait_idle(200);
    n_cmp++;
    if ({issued, err} !== {8'(base + 8'd6), 1'b0} || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_done: issued=%0d err=%b pending=%0d, required %0d 0 0",
               issued, err, exp_q.size(), 8'(base + 8'd6));
    end
  endtask

  task automatic test_watchdog();
    logic [7:0] base;
    int         t;
    int         n;
    base = issued;
    core_never = 1'b1;
    push(4'd7, 4'd3);
    wait_start(10, t);
    count_run(n);
    n_cmp++;
    if (n !== 8) begin
      n_bad++;
      $display("FAIL wdog_cycles: %0d RUN cycles, required 8", n);
    end
    n_cmp++;
    if ({err, issued, busy} !== {1'b1, base, 1'b0}) begin
      n_bad++;
      $display("FAIL wdog_state: err=%b issued=%0d busy=%b, required 1 %0d 0", err, issued, busy, base);
    end
    core_never = 1'b0;
    core_lat = 3;
    push(4'd2, 4'd12);
    wait_idle(40);
    n_cmp++;
    if ({err, issued} !== {1'b1, 8'(base + 8'd1)}) begin
      n_bad++;
      $display("FAIL wdog_recover: err=%b issued=%0d, required 1 %0d", err, issued, 8'(base + 8'd1));
    end
  endtask

  task automatic test_reset_mid_run();
    int t;
    core_lat = 8;
    push(4'd9, 4'd9);
    wait_start(10, t);
    push(4'd1, 4'd2);
    push(4'd3, 4'd4);
    @(negedge clk);
    n_cmp++;
    if ({level, busy} !== {3'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL pre_reset: level=%0d busy=%b, required 2 1", level, busy);
    end
    rst = 1'b1;
    #1;
    exp_q.delete();
    n_cmp++;
    if ({level, core_start, busy, issued, err, in_ready} !==
        {3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_reset: level=%0d start=%b busy=%b issued=%0d err=%b rdy=%b, required 0 0 0 0 0 1",
               level, core_start, busy, issued, err, in_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    n_cmp++;
    if ({level, busy, issued} !== {3'd0, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL post_reset: level=%0d busy=%b issued=%0d, required 0 0 0", level, busy, issued);
    end
  endtask

  task automatic test_wrap();
    core_lat = 3;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(4'($urandom_range(15)), 4'($urandom_range(15)));
    n_cmp++;
    if (level !== 3'd1) begin
      n_bad++;
      $display("FAIL push_after_reset: level=%0d, required 1", level);
    end
    for (int i = 1; i < 255; i++) push(4'($urandom_range(15)), 4'($urandom_range(15)));
    wait_idle(100);
    n_cmp++;
    if (issued !== 8'd255) begin
      n_bad++;
      $display("FAIL issued_255: issued=%0d, required 255", issued);
    end
    push(4'd15, 4'd0);
    wait_idle(40);
    n_cmp++;
    if (issued !== 8'd0) begin
      n_bad++;
      $display("FAIL issued_wrap: issued=%0d, required 0", issued);
    end
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({issued, busy} !== {8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL spurious_done: issued=%0d busy=%b, required 0 0", issued, busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_run();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_issuer.md
OPERAND_ISSUER -- requirements
Module: operand_issuer

Interface
REQ-001 Parameter DEPTH, default 4, meaning FIFO depth in operand pairs; only 4 is supported.
REQ-002 Parameter WDOG, default 8, meaning the maximum number of RUN cycles allowed before a timeout.
REQ-003 Port clk, input, 1 bit, system clock; every register updates on its rising edge.
REQ-004 Port rst, input, 1 bit, asynchronous active-high reset, shared with the downstream compute core.
REQ-005 Port in_valid, input, 1 bit, upstream operand pair valid.
REQ-006 Port in_ready, output, 1 bit, the block can accept a pair this cycle.
REQ-007 Port in_x, input, 4 bits, operand x.
REQ-008 Port in_y, input, 4 bits, operand y.
REQ-009 Port core_start, output, 1 bit, start pulse to the compute core.
REQ-010 Port core_xin, output, 4 bits, x operand to the core, driven from the hold register.
REQ-011 Port core_yin, output, 4 bits, y operand to the core, driven from the hold register.
REQ-012 Port core_done, input, 1 bit, core done flag, high for 1 cycle in the core's final state.
REQ-013 Port busy, output, 1 bit, high when state is not IDLE.
REQ-014 Port level, output, 3 bits, FIFO occupancy, range 0..4.
REQ-015 Port issued, output, 8 bits, count of completed issues; wraps from 255 to 0.
REQ-016 Port err, output, 1 bit, sticky watchdog timeout flag.

Function
REQ-017 in_ready shall equal !full, combinationally; a push occurs on in_valid && in_ready.
REQ-018 The FIFO shall have no full bypass: a push is refused when full, even in a cycle that pops.
REQ-019 Simultaneous push and pop at levels 1..3 shall leave level unchanged and keep data order.
REQ-020 Pointers shall be 2 bits and wrap 3->0; level shall be a separate 3-bit counter.
REQ-021 FSM states shall be IDLE, LOAD, START and RUN.
REQ-022 IDLE->LOAD when level != 0.
REQ-023 LOAD shall pop the FIFO head into the {hold_x, hold_y} registers; LOAD->START unconditionally.
REQ-024 START shall drive core_start=1 for exactly that 1 cycle; START->RUN.
REQ-025 RUN->IDLE when core_done=1; that transition shall increment issued.
REQ-026 RUN shall count cycles; if the count reaches WDOG without core_done, err:=1 and RUN->IDLE, with issued unchanged.
REQ-027 core_start shall be 0 in every state other than START.
REQ-028 core_start shall not depend combinationally on any core output, so no loop through the core idle output is possible.
REQ-029 core_xin and core_yin shall be stable from LOAD+1 through the core_done cycle; the core recomputes x*x every cycle, so the hold registers change only in LOAD.
REQ-030 In IDLE, the hold registers shall retain the last pair.
REQ-031 Nominal issue interval shall be 6 cycles per pair: 1 IDLE, 1 LOAD, 1 START, 3 RUN, with done seen on the 3rd RUN cycle.
REQ-032 core_done arriving in IDLE, LOAD or START shall be ignored.
REQ-033 err shall be cleared only by rst.

Reset
REQ-034 While rst=1: state=IDLE, pointers=0, level=0, hold regs=0, issued=0, err=0, RUN count=0, core_start=0, busy=0.
REQ-035 While rst=1, in_ready shall be 1.
REQ-036 Reset mid-operation shall discard all FIFO contents and any in-flight pair; the core is reset by the same rst.
REQ-037 The first push shall be accepted on the first rising edge with rst=0.

Structure
REQ-038 A shared package shall hold the state enum (2-bit, IDLE=0, LOAD=1, START=2, RUN=3), DEPTH, WDOG, operand width 4 and issued width 8.
REQ-039 The FIFO shall be a sub-module op_fifo (8-bit data {x,y}, DEPTH 4) with ports push, pop, din, dout, full, empty and level.
REQ-040 The FSM, hold registers, watchdog counter and issued counter shall live in operand_issuer.

Verification
REQ-041 Scenario 1 -- push (x=6,y=9), core model asserts done 3 cycles after start -> core_start pulses 1 cycle; core_xin=6 and core_yin=9 stable through done; issued=1; busy=0 afterwards.
REQ-042 Scenario 2 -- push 5 pairs back-to-back with the core stalled -> in_ready=0 after the 4th pair (level=4); 5th pair held off until LOAD pops; all 5 pairs issued in order.
REQ-043 Scenario 3 -- full FIFO with in_valid=1 held during a LOAD pop cycle -> no push that cycle; level 4->3, then 3->4 the next cycle.
REQ-044 Scenario 4 -- core_done never asserted -> err=1 after 8 RUN cycles; FSM returns to IDLE; next pair issues; err stays 1.
REQ-045 Scenario 5 -- rst asserted during RUN with level=2 -> immediately level=0, core_start=0, busy=0, issued=0; no stale pair issued after release.
REQ-046 Scenario 6 -- 256 completed issues -> issued wraps to 0; spurious core_done in IDLE -> issued unchanged.
